// File: rtl/oc8051_cxrom_fetch.sv
// oc8051_cxrom_fetch: initiator side of the oc8051 cxrom port.
// Fetches 32-bit words from a combinational ROM into a circular byte queue and
// presents up to three bytes (the longest 8051 instruction) plus their PC to decode.
// Handles sequential prefetch, jump redirect and 16-bit address wrap.
//
// Optional build macro: CXFETCH_STATS_EN enables the fetch_cnt statistics counter
// (cycles with cxrom_rd=1, saturating, cleared by reset and redirect). When it is
// undefined, fetch_cnt is tied to zero.
//
// Ports:
//   clk            clock, all state on the rising edge
//   rst            asynchronous active-low reset
//   cxrom_addr     byte address to ROM (pc_new during a redirect)
//   cxrom_data_in  ROM word, byte i = mem[addr+i]
//   cxrom_rd       word on cxrom_data_in is captured at this edge
//   pc_load        redirect: flush queue, restart fetch at pc_new
//   pc_new         redirect target
//   consume        bytes taken by decode this cycle (0..3)
//   out_bytes      bytes at out_pc, out_pc+1, out_pc+2 (invalid bytes read 0)
//   out_avail      valid bytes in out_bytes = min(count,3)
//   out_pc         address of out_bytes[7:0]
//   consume_err    sticky: consume exceeded out_avail
//   fetch_cnt      fetch statistics (see macro above)
module oc8051_cxrom_fetch #(
    parameter int unsigned BUF_BYTES = 8,
    parameter logic [15:0] RESET_PC  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] cxrom_addr,
    input  logic [31:0] cxrom_data_in,
    output logic        cxrom_rd,
    input  logic        pc_load,
    input  logic [15:0] pc_new,
    input  logic [1:0]  consume,
    output logic [23:0] out_bytes,
    output logic [1:0]  out_avail,
    output logic [15:0] out_pc,
    output logic        consume_err,
    output logic [15:0] fetch_cnt
);

    localparam int unsigned PTR_W = $clog2(BUF_BYTES);
    localparam int unsigned CNT_W = PTR_W + 1;
    // A word may be written only if four free slots remain after consumption.
    localparam logic [CNT_W-1:0] FILL_LIMIT = CNT_W'(BUF_BYTES - 4);

    logic [7:0]       byte_q [BUF_BYTES];
    logic [15:0]      fetch_addr, fetch_addr_d;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_d, wr_ptr, wr_ptr_d, wr_base;
    logic [CNT_W-1:0] count, count_d, rem;
    logic [15:0]      out_pc_d;
    logic             err_d;
    logic [1:0]       take;
    logic             wr_en;

    // Next-state: redirect overrides consume; otherwise consume then refill.
    always_comb begin
        take         = (consume > out_avail) ? out_avail : consume;
        rem          = count - CNT_W'(take);
        fetch_addr_d = fetch_addr;
        rd_ptr_d     = rd_ptr;
        wr_ptr_d     = wr_ptr;
        wr_base      = wr_ptr;
        count_d      = count;
        out_pc_d     = out_pc;
        err_d        = consume_err;
        wr_en        = 1'b0;
        if (pc_load) begin
            wr_en        = 1'b1;
            wr_base      = '0;
            rd_ptr_d     = '0;
            wr_ptr_d     = PTR_W'(4);
            count_d      = CNT_W'(4);
            out_pc_d     = pc_new;
            fetch_addr_d = pc_new + 16'd4;
        end else begin
            if (consume > out_avail) begin
                err_d = 1'b1;
            end
            rd_ptr_d = rd_ptr + PTR_W'(take);
            out_pc_d = out_pc + 16'(take);
            if (rem <= FILL_LIMIT) begin
                wr_en        = 1'b1;
                wr_ptr_d     = wr_ptr + PTR_W'(4);
                fetch_addr_d = fetch_addr + 16'd4;
                count_d      = rem + CNT_W'(4);
            end else begin
                count_d = rem;
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_addr  <= RESET_PC;
            out_pc      <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            consume_err <= 1'b0;
        end else begin
            fetch_addr  <= fetch_addr_d;
            out_pc      <= out_pc_d;
            rd_ptr      <= rd_ptr_d;
            wr_ptr      <= wr_ptr_d;
            count       <= count_d;
            consume_err <= err_d;
        end
    end

    // Byte storage; contents beyond count are never presented, so no reset needed.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            for (int i = 0; i < 4; i++) begin
                byte_q[wr_base + PTR_W'(i)] <= cxrom_data_in[8*i +: 8];
            end
        end
    end

    // ROM side: redirect target goes straight to the ROM so its word lands this edge.
    assign cxrom_addr = (rst && pc_load) ? pc_new : fetch_addr;
    assign cxrom_rd   = rst & wr_en;

    // Decode side, derived from registered state only.
    always_comb begin
        out_avail = (count >= CNT_W'(3)) ? 2'd3 : count[1:0];
        out_bytes = '0;
        for (int i = 0; i < 3; i++) begin
            if (2'(i) < out_avail) begin
                out_bytes[8*i +: 8] = byte_q[rd_ptr + PTR_W'(i)];
            end
        end
    end

`ifdef CXFETCH_STATS_EN
    logic [15:0] fetch_cnt_q;

    // Fetch counter; the redirect fetch counts as the first after the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
        end else if (pc_load) begin
            fetch_cnt_q <= 16'd1;
        end else if (wr_en && (fetch_cnt_q != 16'hFFFF)) begin
            fetch_cnt_q <= fetch_cnt_q + 16'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
`else
    assign fetch_cnt = 16'h0000;
`endif

endmodule
